fnd_scan_apb: RTL

APB-mapped, parametrised multi-digit 7-segment scan controller; successor to the fixed 4-digit FND peripheral. Converts a binary data register to BCD with a sequential double-dabble engine, or shows it raw in hex mode. Double-buffers the result so the display never tears mid-scan. Sits on the APB bus beside the other peripherals and drives the board's FND common and segment pins directly.

---
 rtl/fnd_scan_apb.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/fnd_scan_apb.sv
// rtl/fnd_scan_apb.sv - APB multi-digit 7-segment scan controller with BCD conversion
//
// Purpose: holds CR/DR/DPR/PSR/SR registers on APB, converts DR to BCD with a
// sequential double-dabble engine (or passes nibbles through in hex mode),
// double-buffers the result and time-multiplexes it onto the FND pins.
// Ports:
//   PCLK, PRESET                   clock, synchronous active-high reset
//   PADDR/PWDATA/PWRITE/PENABLE/PSEL  APB request, PADDR[4:2] selects register
//   PRDATA/PREADY                  registered APB response, one wait state
//   fndComm                        digit enables, active-low, bit 0 = rightmost
//   fndFont                        segments, active-low, bit 7 = dp
// Build option: FND_LZB_EN implements CR.LZB (leading-zero blanking).
module fnd_scan_apb #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 100_000
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [4:0]        PADDR,
  input  logic [31:0]       PWDATA,
  input  logic              PWRITE,
  input  logic              PENABLE,
  input  logic              PSEL,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic [DIGITS-1:0] fndComm,
  output logic [7:0]        fndFont
);
  localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam int BCD_W = 40;  // ten BCD digits cover any 32-bit value
  localparam logic [DW-1:0] LAST_DIG = DW'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_IT  = CW'(BIN_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  // APB / register state
  logic              pready_q, en_q, hex_q, lzb;
  logic [31:0]       prdata_q, dr_q, rdata;
  logic [DIGITS-1:0] dpr_q;
  logic [19:0]       psr_q;
  // conversion and buffers
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       bin_q;
  logic [BCD_W-1:0]  bcd_q, bcd_adj;
  logic              mode_hex_q, ovf_q, pend_v_q;
  logic [4*DIGITS-1:0] pend_q, disp_q;
  logic [DIGITS-1:0] pend_blank_q, disp_blank_q, blank_d;
  // scan
  logic [19:0]       presc_q;
  logic [DW-1:0]     digit_q;
  logic [DIGITS-1:0] comm_q;
  logic [7:0]        font_q;

  logic access, wr_cr, wr_dr, wr_dpr, wr_psr, start, busy, tick, wrap, disp_load, done_fire;
  logic unused_ok;

  assign access = PSEL & PENABLE & ~pready_q;
  assign wr_cr  = access & PWRITE & (PADDR[4:2] == 3'd0);
  assign wr_dr  = access & PWRITE & (PADDR[4:2] == 3'd1);
  assign wr_dpr = access & PWRITE & (PADDR[4:2] == 3'd2);
  assign wr_psr = access & PWRITE & (PADDR[4:2] == 3'd3);
  // a new DR value or a mode flip restarts conversion, aborting any in flight
  assign start  = wr_dr | (wr_cr & (PWDATA[1] != hex_q));
  assign busy   = (state_q != S_IDLE);
  assign done_fire = (state_q == S_DONE) & ~start;
  assign tick   = en_q & (presc_q == psr_q);
  assign wrap   = tick & (digit_q == LAST_DIG);
  assign disp_load = pend_v_q & (wrap | ~en_q);
  assign unused_ok = ^PADDR[1:0];

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign fndComm = comm_q;
  assign fndFont = font_q;

  always_comb begin
    rdata = 32'd0;
    case (PADDR[4:2])
      3'd0: rdata = {29'd0, lzb, hex_q, en_q};
      3'd1: rdata = dr_q;
      3'd2: rdata = 32'(dpr_q);
      3'd3: rdata = {12'd0, psr_q};
      3'd4: rdata = {30'd0, ovf_q, busy};
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pready_q <= 1'b0;
      prdata_q <= 32'd0;
      en_q     <= 1'b0;
      hex_q    <= 1'b0;
      dr_q     <= 32'd0;
      dpr_q    <= '0;
      psr_q    <= 20'(SCAN_DIV);
    end else begin
      pready_q <= access;
      if (access & ~PWRITE) prdata_q <= rdata;
      if (wr_cr) begin
        en_q  <= PWDATA[0];
        hex_q <= PWDATA[1];
      end
      if (wr_dr)  dr_q  <= PWDATA;
      if (wr_dpr) dpr_q <= PWDATA[DIGITS-1:0];
      if (wr_psr) psr_q <= PWDATA[19:0];
    end
  end

`ifdef FND_LZB_EN
  logic lzb_q;
  always_ff @(posedge PCLK) begin
    if (PRESET)     lzb_q <= 1'b0;
    else if (wr_cr) lzb_q <= PWDATA[2];
  end
  assign lzb = lzb_q;

  // blank zero digits from the MSD down until the first non-zero; digit 0 always shown
  always_comb begin
    logic lead;
    blank_d = '0;
    lead    = lzb & ~mode_hex_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (bcd_q[4*i +: 4] == 4'd0)) blank_d[i] = 1'b1;
      else lead = 1'b0;
    end
  end
`else
  assign lzb     = 1'b0;
  assign blank_d = '0;
`endif

  // add-3 correction on every BCD nibble that would overflow on the next shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < BCD_W / 4; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bin_q        <= 32'd0;
      bcd_q        <= '0;
      mode_hex_q   <= 1'b0;
      ovf_q        <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_q       <= '0;
      pend_blank_q <= '0;
      disp_q       <= '0;
      disp_blank_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          mode_hex_q <= hex_q;
          cnt_q      <= '0;
          if (hex_q) begin
            bcd_q   <= {8'd0, dr_q};
            state_q <= S_DONE;
          end else begin
            bcd_q   <= '0;
            bin_q   <= dr_q << (32 - BIN_W);  // MSB-align so bit 31 feeds the BCD chain
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[31]};
          bin_q <= {bin_q[30:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_IT) state_q <= S_DONE;
        end
        S_DONE: begin
          if (done_fire) begin
            pend_q       <= bcd_q[4*DIGITS-1:0];
            pend_blank_q <= blank_d;
            ovf_q        <= ~mode_hex_q & (|bcd_q[BCD_W-1:4*DIGITS]);
          end
          state_q <= S_IDLE;
        end
        default: ;
      endcase
      if (start) state_q <= S_LOAD;

      // a result landing on the wrap edge is not yet pending, so it waits one more scan
      if (done_fire)      pend_v_q <= 1'b1;
      else if (disp_load) pend_v_q <= 1'b0;
      if (disp_load) begin
        disp_q       <= pend_q;
        disp_blank_q <= pend_blank_q;
      end
    end
  end

  function automatic logic [6:0] font7(input logic [3:0] d);
    case (d)
      4'h0: font7 = 7'h40; 4'h1: font7 = 7'h79; 4'h2: font7 = 7'h24; 4'h3: font7 = 7'h30;
      4'h4: font7 = 7'h19; 4'h5: font7 = 7'h12; 4'h6: font7 = 7'h02; 4'h7: font7 = 7'h78;
      4'h8: font7 = 7'h00; 4'h9: font7 = 7'h10; 4'hA: font7 = 7'h08; 4'hB: font7 = 7'h03;
      4'hC: font7 = 7'h46; 4'hD: font7 = 7'h21; 4'hE: font7 = 7'h06; default: font7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      presc_q <= 20'd0;
      digit_q <= '0;
      comm_q  <= '1;
      font_q  <= 8'hFF;
    end else begin
      if (~en_q | wr_psr | tick) presc_q <= 20'd0;
      else                       presc_q <= presc_q + 20'd1;
      if (~en_q)     digit_q <= '0;
      else if (tick) digit_q <= wrap ? '0 : digit_q + DW'(1);
      if (~en_q) begin
        comm_q <= '1;
        font_q <= 8'hFF;
      end else begin
        comm_q <= ~(DIGITS'(1) << digit_q);
        font_q <= {~dpr_q[digit_q],
                   disp_blank_q[digit_q] ? 7'h7F : font7(disp_q[{digit_q, 2'b00} +: 4])};
      end
    end
  end
endmodule
